// File: rtl/conv_result_reader.sv
// Streams a latched convolution result grid out one element per handshake, row-major.
// Reports element position, last-element flag, rejection pulses and stream counters.
module conv_result_reader #(
   parameter int ELEM_W = 16,
   parameter int GRID   = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [2:0]                    res_m,
   input  logic [2:0]                    res_n,
   input  logic [GRID*GRID*ELEM_W-1:0]   res_data,
   input  logic                          res_valid,
   input  logic                          dim_error,
   input  logic                          elem_ready,
   output logic                          elem_valid,
   output logic [ELEM_W-1:0]             elem_data,
   output logic [2:0]                    elem_row,
   output logic [2:0]                    elem_col,
   output logic                          elem_last,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   output logic [4:0]                    elem_count,
   output logic [9:0]                    cycle_count
);

   localparam int          BUS_W  = GRID * GRID * ELEM_W;
   localparam logic [2:0]  GRID_L = 3'(GRID);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [BUS_W-1:0]    data_q;
   logic [2:0]          m_q;
   logic [2:0]          n_q;
   logic [2:0]          row_q;
   logic [2:0]          col_q;
   logic [2:0]          row_d;
   logic [2:0]          col_d;
   logic                valid_q;
   logic [ELEM_W-1:0]   elem_q;
   logic                last_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic [4:0]          count_q;
   logic [9:0]          cycles_q;
   logic                accept_s;
   logic                next_last_s;

   function automatic logic [ELEM_W-1:0] get_elem(input logic [BUS_W-1:0] d,
                                                  input logic [2:0] r,
                                                  input logic [2:0] c);
      int idx;
      idx = int'(r) * GRID + int'(c);
      return d[idx*ELEM_W +: ELEM_W];
   endfunction

   assign accept_s = start && res_valid && !dim_error &&
                     (res_m >= 3'd1) && (res_m <= GRID_L) &&
                     (res_n >= 3'd1) && (res_n <= GRID_L);

   // Row-major advance of the read pointer after an accepted element.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (col_q == n_q - 3'd1) begin
         col_d = 3'd0;
         row_d = row_q + 3'd1;
      end else begin
         col_d = col_q + 3'd1;
      end
   end

   assign next_last_s = (row_d == m_q - 3'd1) && (col_d == n_q - 3'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         data_q   <= '0;
         m_q      <= 3'd0;
         n_q      <= 3'd0;
         row_q    <= 3'd0;
         col_q    <= 3'd0;
         valid_q  <= 1'b0;
         elem_q   <= '0;
         last_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         count_q  <= 5'd0;
         cycles_q <= 10'd0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && accept_s) begin
                  data_q   <= res_data;
                  m_q      <= res_m;
                  n_q      <= res_n;
                  row_q    <= 3'd0;
                  col_q    <= 3'd0;
                  elem_q   <= res_data[ELEM_W-1:0];
                  last_q   <= (res_m == 3'd1) && (res_n == 3'd1);
                  valid_q  <= 1'b1;
                  busy_q   <= 1'b1;
                  count_q  <= 5'd0;
                  cycles_q <= 10'd0;
                  state_q  <= SEND;
               end else if (start) begin
                  err_q <= 1'b1;
               end else begin
                  valid_q <= 1'b0;
               end
            end
            SEND: begin
               if (cycles_q != 10'd1023) begin
                  cycles_q <= cycles_q + 10'd1;
               end
               if (elem_ready) begin
                  count_q <= count_q + 5'd1;
                  if (last_q) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     row_q  <= row_d;
                     col_q  <= col_d;
                     elem_q <= get_elem(data_q, row_d, col_d);
                     last_q <= next_last_s;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign elem_valid  = valid_q;
   assign elem_data   = elem_q;
   assign elem_row    = row_q;
   assign elem_col    = col_q;
   assign elem_last   = last_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign elem_count  = count_q;
   assign cycle_count = cycles_q;

endmodule

// File: tb/tb_conv_result_reader.sv
// Directed bench for conv_result_reader: table-driven streams and rejections,
// plus a hand-written mid-stream restart/reset sequence.
module tb_conv_result_reader;

   logic          clk;
   logic          reset;
   logic          start;
   logic [2:0]    res_m;
   logic [2:0]    res_n;
   logic [399:0]  res_data;
   logic          res_valid;
   logic          dim_error;
   logic          elem_ready;
   logic          elem_valid;
   logic [15:0]   elem_data;
   logic [2:0]    elem_row;
   logic [2:0]    elem_col;
   logic          elem_last;
   logic          busy;
   logic          done;
   logic          err;
   logic [4:0]    elem_count;
   logic [9:0]    cycle_count;

   int checks;
   int errors;
   int last_count;
   int last_cycles;

   conv_result_reader #(.ELEM_W(16), .GRID(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .res_m       (res_m),
      .res_n       (res_n),
      .res_data    (res_data),
      .res_valid   (res_valid),
      .dim_error   (dim_error),
      .elem_ready  (elem_ready),
      .elem_valid  (elem_valid),
      .elem_data   (elem_data),
      .elem_row    (elem_row),
      .elem_col    (elem_col),
      .elem_last   (elem_last),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .elem_count  (elem_count),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mode 0: ready always, 1: ready on odd SEND cycles, 2: ready on even SEND cycles
   typedef struct {
      logic [2:0]  m;
      logic [2:0]  n;
      int          mode;
      logic [15:0] base;
      int          exp_count;
      int          exp_cycles;
   } stream_t;

   typedef struct {
      logic        valid;
      logic        dimerr;
      logic [2:0]  m;
      logic [2:0]  n;
   } reject_t;

   stream_t streams[5];
   reject_t rejects[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [399:0] build_data(input logic [15:0] base);
      logic [399:0] d;
      d = '0;
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            d[(r*5+c)*16 +: 16] = base + 16'(r*10 + c);
         end
      end
      return d;
   endfunction

   task automatic run_stream(input stream_t s);
      int k;
      int total;
      int r;
      int c;
      total = int'(s.m) * int'(s.n);
      k = 0;
      res_m = s.m;
      res_n = s.n;
      res_data = build_data(s.base);
      res_valid = 1'b1;
      dim_error = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("accept_valid", {31'd0, elem_valid}, 32'd1);
      chk("accept_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 200 && k < total; i++) begin
         case (s.mode)
            0: elem_ready = 1'b1;
            1: elem_ready = (i % 2) == 1;
            default: elem_ready = (i % 2) == 0;
         endcase
         @(negedge clk);
         r = k / int'(s.n);
         c = k % int'(s.n);
         chk("valid", {31'd0, elem_valid}, 32'd1);
         chk("data", {16'd0, elem_data}, {16'd0, s.base + 16'(r*10 + c)});
         chk("row", {29'd0, elem_row}, 32'(r));
         chk("col", {29'd0, elem_col}, 32'(c));
         chk("last", {31'd0, elem_last}, (k == total - 1) ? 32'd1 : 32'd0);
         if (elem_ready) k++;
         @(posedge clk); #1;
      end
      elem_ready = 1'b1;
      chk("stream_complete", 32'(k), 32'(total));
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("done_valid", {31'd0, elem_valid}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("elem_count", {27'd0, elem_count}, 32'(s.exp_count));
      chk("cycle_count", {22'd0, cycle_count}, 32'(s.exp_cycles));
      last_count = s.exp_count;
      last_cycles = s.exp_cycles;
      @(posedge clk); #1;
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_valid", {31'd0, elem_valid}, 32'd0);
      chk("hold_count", {27'd0, elem_count}, 32'(s.exp_count));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, elem_valid}, 32'd0);
      chk({tag, "_data"}, {16'd0, elem_data}, 32'd0);
      chk({tag, "_row"}, {29'd0, elem_row}, 32'd0);
      chk({tag, "_col"}, {29'd0, elem_col}, 32'd0);
      chk({tag, "_last"}, {31'd0, elem_last}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_count"}, {27'd0, elem_count}, 32'd0);
      chk({tag, "_cycles"}, {22'd0, cycle_count}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      last_count = 0;
      last_cycles = 0;

      streams[0] = '{m: 3'd2, n: 3'd3, mode: 0, base: 16'h0000,  exp_count: 6,  exp_cycles: 6};
      streams[1] = '{m: 3'd5, n: 3'd5, mode: 1, base: 16'h0000,  exp_count: 25, exp_cycles: 50};
      streams[2] = '{m: 3'd5, n: 3'd5, mode: 2, base: 16'h0100,  exp_count: 25, exp_cycles: 49};
      streams[3] = '{m: 3'd1, n: 3'd5, mode: 1, base: 16'h1000,  exp_count: 5,  exp_cycles: 10};
      streams[4] = '{m: 3'd1, n: 3'd1, mode: 0, base: 16'hABCD,  exp_count: 1,  exp_cycles: 1};

      rejects[0] = '{valid: 1'b1, dimerr: 1'b1, m: 3'd2, n: 3'd2};
      rejects[1] = '{valid: 1'b0, dimerr: 1'b0, m: 3'd2, n: 3'd2};
      rejects[2] = '{valid: 1'b1, dimerr: 1'b0, m: 3'd6, n: 3'd2};
      rejects[3] = '{valid: 1'b1, dimerr: 1'b0, m: 3'd2, n: 3'd0};
      rejects[4] = '{valid: 1'b1, dimerr: 1'b0, m: 3'd0, n: 3'd7};

      reset = 1'b1;
      start = 1'b0;
      res_m = 3'd0;
      res_n = 3'd0;
      res_data = '0;
      res_valid = 1'b0;
      dim_error = 1'b0;
      elem_ready = 1'b1;
      #12;
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         run_stream(streams[i]);
      end

      for (int i = 0; i < 5; i++) begin
         res_valid = rejects[i].valid;
         dim_error = rejects[i].dimerr;
         res_m = rejects[i].m;
         res_n = rejects[i].n;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk("rej_err", {31'd0, err}, 32'd1);
         chk("rej_valid", {31'd0, elem_valid}, 32'd0);
         chk("rej_busy", {31'd0, busy}, 32'd0);
         chk("rej_count", {27'd0, elem_count}, 32'(last_count));
         chk("rej_cycles", {22'd0, cycle_count}, 32'(last_cycles));
         @(posedge clk); #1;
         chk("rej_err_end", {31'd0, err}, 32'd0);
         chk("rej_valid_end", {31'd0, elem_valid}, 32'd0);
      end

      // 3x3 stream: restart attempt with new data mid-stream, then async reset
      res_m = 3'd3;
      res_n = 3'd3;
      res_data = build_data(16'h0200);
      res_valid = 1'b1;
      dim_error = 1'b0;
      elem_ready = 1'b1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("mid_valid", {31'd0, elem_valid}, 32'd1);
         chk("mid_data", {16'd0, elem_data}, {16'd0, 16'h0200 + 16'((k/3)*10 + (k%3))});
         chk("mid_err", {31'd0, err}, 32'd0);
         if (k == 1) begin
            res_data = build_data(16'h7000);
            res_m = 3'd1;
            res_n = 3'd1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
      end
      #3;
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_done", {31'd0, done}, 32'd0);
         chk("post_reset_valid", {31'd0, elem_valid}, 32'd0);
      end
      @(posedge clk); #1;
      run_stream('{m: 3'd3, n: 3'd3, mode: 0, base: 16'h0300, exp_count: 9, exp_cycles: 9});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach summary");
      $fatal(1, "timeout");
   end

endmodule
